// File: rtl/dual_issue_scoreboard_ctrl.sv
// Dual-issue in-order scoreboard issue controller with flush FSM and stall counter.
// Optional: define SB_WB_BYPASS_EN to let same-cycle writebacks free registers for issue checks.
module dual_issue_scoreboard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_flush,
    input  logic                   i_exec_ready,
    input  logic                   i_s0_valid,
    input  logic [REG_AW-1:0]      i_s0_rs1,
    input  logic [REG_AW-1:0]      i_s0_rs2,
    input  logic [REG_AW-1:0]      i_s0_rd,
    input  logic                   i_s0_we,
    input  logic                   i_s1_valid,
    input  logic [REG_AW-1:0]      i_s1_rs1,
    input  logic [REG_AW-1:0]      i_s1_rs2,
    input  logic [REG_AW-1:0]      i_s1_rd,
    input  logic                   i_s1_we,
    input  logic                   i_wb0_valid,
    input  logic [REG_AW-1:0]      i_wb0_rd,
    input  logic                   i_wb1_valid,
    input  logic [REG_AW-1:0]      i_wb1_rd,
    output logic                   o_s0_issue,
    output logic                   o_s1_issue,
    output logic [2**REG_AW-1:0]   o_busy,
    output logic                   o_flushing,
    output logic [STALL_CNT_W-1:0] o_stall_cnt
);

    localparam int NREG = 2**REG_AW;
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(FLUSH_CYCLES - 1);

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t                 state_q, state_d;
    logic [FC_W-1:0]        fcnt_q, fcnt_d;
    logic [NREG-1:0]        busy_q, busy_d;
    logic [NREG-1:0]        wb_clr, iss_set, busy_eff;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   s0_ok, s1_ok, s1_dep;

    function automatic logic is_busy(input logic [NREG-1:0] b,
                                     input logic [REG_AW-1:0] r);
        return (r != '0) && b[r];
    endfunction

    always_comb begin
        wb_clr = '0;
        if (i_wb0_valid) wb_clr[i_wb0_rd] = 1'b1;
        if (i_wb1_valid) wb_clr[i_wb1_rd] = 1'b1;
    end

`ifdef SB_WB_BYPASS_EN
    assign busy_eff = busy_q & ~wb_clr;
`else
    assign busy_eff = busy_q;
`endif

    assign s0_ok = i_s0_valid
                 & !is_busy(busy_eff, i_s0_rs1)
                 & !is_busy(busy_eff, i_s0_rs2)
                 & !(i_s0_we & is_busy(busy_eff, i_s0_rd));

    assign s1_ok = i_s1_valid
                 & !is_busy(busy_eff, i_s1_rs1)
                 & !is_busy(busy_eff, i_s1_rs2)
                 & !(i_s1_we & is_busy(busy_eff, i_s1_rd));

    // Younger slot must not read or overwrite what the older slot writes.
    assign s1_dep = i_s0_we & (i_s0_rd != '0)
                  & ((i_s1_rs1 == i_s0_rd) | (i_s1_rs2 == i_s0_rd)
                     | (i_s1_we & (i_s1_rd == i_s0_rd)));

    assign o_s0_issue = !i_reset & (state_q == ST_RUN) & !i_flush
                      & i_exec_ready & s0_ok;
    assign o_s1_issue = o_s0_issue & s1_ok & !s1_dep;

    always_comb begin
        iss_set = '0;
        if (o_s0_issue && i_s0_we) iss_set[i_s0_rd] = 1'b1;
        if (o_s1_issue && i_s1_we) iss_set[i_s1_rd] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        busy_d  = busy_q;
        unique case (state_q)
            ST_RUN: begin
                if (i_flush) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FC_RELOAD;
                    busy_d  = '0;
                end else begin
                    busy_d = (busy_q & ~wb_clr) | iss_set;
                end
            end
            ST_FLUSH: begin
                busy_d = '0;
                if (i_flush) begin
                    fcnt_d = FC_RELOAD;
                end else if (fcnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    fcnt_d = fcnt_q - 1'b1;
                end
            end
        endcase
        busy_d[0] = 1'b0;
    end

    always_comb begin
        stall_d = stall_q;
        if (i_s0_valid && !o_s0_issue && !(&stall_q))
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_RUN;
            fcnt_q  <= '0;
            busy_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            busy_q  <= busy_d;
            stall_q <= stall_d;
        end
    end

    assign o_busy      = busy_q;
    assign o_flushing  = (state_q == ST_FLUSH);
    assign o_stall_cnt = stall_q;

endmodule

// File: tb/tb_dual_issue_scoreboard_ctrl.sv
// Directed table-driven bench for dual_issue_scoreboard_ctrl, plus flush,
// stall-saturation and async-reset sequences (second instance with 4-bit counter).
module tb_dual_issue_scoreboard_ctrl;

`ifdef SB_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    typedef struct {
        logic       fl, rdy;
        logic       s0v;
        logic [4:0] a1, a2, ad;
        logic       aw;
        logic       s1v;
        logic [4:0] b1, b2, bd;
        logic       bw;
        logic       w0v;
        logic [4:0] w0;
        logic       w1v;
        logic [4:0] w1;
        logic        e0, e1;
        logic [31:0] eb;
        logic        ef;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, rdy;
    logic        s0v, s0we, s1v, s1we, w0v, w1v;
    logic [4:0]  s0r1, s0r2, s0rd, s1r1, s1r2, s1rd, w0rd, w1rd;
    logic        iss0, iss1, fl_o, iss0_4, iss1_4, fl_o4;
    logic [31:0] busy, busy4;
    logic [15:0] stall;
    logic [3:0]  stall4;

    int n_vec = 0;
    int n_bad = 0;
    int exp_st16 = 0;
    int exp_st4 = 0;

    always #5 clk = ~clk;

    dual_issue_scoreboard_ctrl dut (
        .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_exec_ready(rdy),
        .i_s0_valid(s0v), .i_s0_rs1(s0r1), .i_s0_rs2(s0r2), .i_s0_rd(s0rd),
        .i_s0_we(s0we),
        .i_s1_valid(s1v), .i_s1_rs1(s1r1), .i_s1_rs2(s1r2), .i_s1_rd(s1rd),
        .i_s1_we(s1we),
        .i_wb0_valid(w0v), .i_wb0_rd(w0rd), .i_wb1_valid(w1v), .i_wb1_rd(w1rd),
        .o_s0_issue(iss0), .o_s1_issue(iss1), .o_busy(busy),
        .o_flushing(fl_o), .o_stall_cnt(stall)
    );

    dual_issue_scoreboard_ctrl #(.STALL_CNT_W(4)) dut4 (
        .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_exec_ready(rdy),
        .i_s0_valid(s0v), .i_s0_rs1(s0r1), .i_s0_rs2(s0r2), .i_s0_rd(s0rd),
        .i_s0_we(s0we),
        .i_s1_valid(s1v), .i_s1_rs1(s1r1), .i_s1_rs2(s1r2), .i_s1_rd(s1rd),
        .i_s1_we(s1we),
        .i_wb0_valid(w0v), .i_wb0_rd(w0rd), .i_wb1_valid(w1v), .i_wb1_rd(w1rd),
        .o_s0_issue(iss0_4), .o_s1_issue(iss1_4), .o_busy(busy4),
        .o_flushing(fl_o4), .o_stall_cnt(stall4)
    );

    function automatic vec_t mk(
        input logic fl, r, s0, input logic [4:0] a1, a2, ad, input logic aw,
        input logic s1, input logic [4:0] b1, b2, bd, input logic bw,
        input logic w0v_, input logic [4:0] w0_, input logic w1v_,
        input logic [4:0] w1_, input logic e0, e1, input logic [31:0] eb,
        input logic ef);
        vec_t v;
        v.fl = fl; v.rdy = r;
        v.s0v = s0; v.a1 = a1; v.a2 = a2; v.ad = ad; v.aw = aw;
        v.s1v = s1; v.b1 = b1; v.b2 = b2; v.bd = bd; v.bw = bw;
        v.w0v = w0v_; v.w0 = w0_; v.w1v = w1v_; v.w1 = w1_;
        v.e0 = e0; v.e1 = e1; v.eb = eb; v.ef = ef;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        flush = v.fl; rdy = v.rdy;
        s0v = v.s0v; s0r1 = v.a1; s0r2 = v.a2; s0rd = v.ad; s0we = v.aw;
        s1v = v.s1v; s1r1 = v.b1; s1r2 = v.b2; s1rd = v.bd; s1we = v.bw;
        w0v = v.w0v; w0rd = v.w0; w1v = v.w1v; w1rd = v.w1;
    endtask

    task automatic step(input string nm, input vec_t v);
        drive(v);
        #1;
        chk({nm, ".s0_issue"}, 32'(iss0), 32'(v.e0));
        chk({nm, ".s1_issue"}, 32'(iss1), 32'(v.e1));
        chk({nm, ".s0_issue4"}, 32'(iss0_4), 32'(v.e0));
        if (v.s0v && !v.e0) begin
            if (exp_st16 < 65535) exp_st16++;
            if (exp_st4 < 15) exp_st4++;
        end
        @(posedge clk);
        #1;
        chk({nm, ".busy"}, busy, v.eb);
        chk({nm, ".busy4"}, busy4, v.eb);
        chk({nm, ".flushing"}, 32'(fl_o), 32'(v.ef));
        chk({nm, ".stall16"}, 32'(stall), 32'(exp_st16));
        chk({nm, ".stall4"}, 32'(stall4), 32'(exp_st4));
        @(negedge clk);
    endtask

    vec_t tbl [19];
    vec_t idle;
    logic [31:0] eb;

    initial begin
        idle = mk(0,1, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0);
        tbl[0]  = mk(0,1, 1,1,2,3,1, 1,0,0,4,1, 0,0,0,0, 1,1,32'h18,0);
        tbl[1]  = mk(0,1, 1,3,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,32'h18,0);
        tbl[2]  = mk(0,1, 1,3,0,0,0, 0,0,0,0,0, 1,3,0,0, BYP,0,32'h10,0);
        tbl[3]  = mk(0,1, 1,3,0,0,0, 0,0,0,0,0, 0,0,0,0, 1,0,32'h10,0);
        tbl[4]  = mk(0,1, 0,0,0,0,0, 0,0,0,0,0, 1,4,0,0, 0,0,32'h0,0);
        tbl[5]  = mk(0,1, 1,0,0,5,1, 1,0,5,0,0, 0,0,0,0, 1,0,32'h20,0);
        tbl[6]  = mk(0,1, 0,0,0,0,0, 0,0,0,0,0, 1,5,0,0, 0,0,32'h0,0);
        tbl[7]  = mk(0,1, 1,0,0,5,1, 1,0,0,5,1, 0,0,0,0, 1,0,32'h20,0);
        tbl[8]  = mk(0,1, 0,0,0,0,0, 0,0,0,0,0, 1,5,0,0, 0,0,32'h0,0);
        tbl[9]  = mk(0,1, 1,0,0,0,1, 1,0,5,8,1, 0,0,0,0, 1,1,32'h100,0);
        tbl[10] = mk(0,0, 1,0,0,1,1, 0,0,0,0,0, 0,0,0,0, 0,0,32'h100,0);
        tbl[11] = mk(0,1, 1,0,0,7,1, 0,0,0,0,0, 1,7,1,8, 1,0,32'h80,0);
        tbl[12] = mk(0,1, 1,0,0,9,1, 0,0,0,0,0, 0,0,0,0, 1,0,32'h280,0);
        tbl[13] = mk(0,1, 1,0,0,9,1, 0,0,0,0,0, 0,0,0,0, 0,0,32'h280,0);
        tbl[14] = mk(0,1, 1,0,0,0,0, 1,7,0,0,0, 0,0,0,0, 1,0,32'h280,0);
        tbl[15] = mk(0,1, 0,0,0,0,0, 0,0,0,0,0, 1,9,1,9, 0,0,32'h80,0);
        tbl[16] = mk(0,1, 0,0,0,0,0, 0,0,0,0,0, 1,7,0,0, 0,0,32'h0,0);
        tbl[17] = mk(0,1, 1,0,0,0,1, 0,0,0,0,0, 1,12,0,0, 1,0,32'h0,0);
        tbl[18] = mk(0,1, 0,0,0,0,0, 1,0,0,3,1, 0,0,0,0, 0,0,32'h0,0);

        rst = 1'b1;
        drive(mk(0,1, 1,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0));
        @(negedge clk);
        chk("reset.s0_issue", 32'(iss0), 32'd0);
        chk("reset.busy", busy, 32'd0);
        chk("reset.stall", 32'(stall), 32'd0);
        chk("reset.flushing", 32'(fl_o), 32'd0);
        drive(idle);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 19; i++) step($sformatf("vec%0d", i), tbl[i]);

        eb = 32'h0;
        for (int r = 1; r < 32; r++) begin
            eb[r] = 1'b1;
            step("fill", mk(0,1, 1,0,0,5'(r),1, 0,0,0,0,0, 0,0,0,0, 1,0,eb,0));
        end
        chk("fill.busy_all", busy, 32'hFFFF_FFFE);

        step("fl1", mk(1,1, 1,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,1));
        step("fl2", mk(0,1, 1,0,0,0,0, 0,0,0,0,0, 1,3,0,0, 0,0,0,1));
        step("fl3", mk(0,1, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0));
        step("fl4", mk(0,1, 1,0,0,6,1, 0,0,0,0,0, 0,0,0,0, 1,0,32'h40,0));

        step("fx1", mk(1,1, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,1));
        step("fx2", mk(1,1, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,1));
        step("fx3", mk(0,1, 1,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,1));
        step("fx4", mk(0,1, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0));
        step("fx5", mk(0,1, 1,0,0,2,1, 0,0,0,0,0, 0,0,0,0, 1,0,32'h4,0));

        for (int i = 0; i < 20; i++)
            step("sat", mk(0,0, 1,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,32'h4,0));
        chk("sat.stall4", 32'(stall4), 32'd15);

        step("rf1", mk(1,1, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,1));
        drive(mk(0,1, 1,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0));
        #2;
        rst = 1'b1;
        #1;
        chk("arst.flushing", 32'(fl_o), 32'd0);
        chk("arst.busy", busy, 32'd0);
        chk("arst.stall16", 32'(stall), 32'd0);
        chk("arst.stall4", 32'(stall4), 32'd0);
        chk("arst.s0_issue", 32'(iss0), 32'd0);
        exp_st16 = 0;
        exp_st4 = 0;
        drive(idle);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        step("post", mk(0,1, 1,0,0,3,1, 0,0,0,0,0, 0,0,0,0, 1,0,32'h8,0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
